mem_read_ctrl: RTL and testbench
================================

# mem_read_ctrl

Read-side sequencer between the processor control unit and the synchronous data RAM. On a one-cycle request it issues a single RAM read, waits out the fixed RAM latency, and presents the fetched word with a one-cycle valid strobe. That word is the source for the bus/AC load path. An internal address pointer supports sequential (post-increment) reads for operand streaming.

## Interface
- DATA_WIDTH, 8, width of RAM words and rd_data
- ADDR_WIDTH, 16, width of RAM address and pointer
- MEM_LATENCY, 1, RAM edges from address sample to mem_q valid (legal 1..7)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  read request, sampled on rising edge
- rd_inc  in  1  sampled with rd_req; 1 = use internal pointer, 0 = use rd_addr
- rd_addr  in  ADDR_WIDTH  explicit read address
- rd_busy  out  1  read in progress; new requests not accepted
- rd_valid  out  1  one-cycle strobe, rd_data updated this cycle
- rd_data  out  DATA_WIDTH  last fetched word, held until next capture
- rd_ptr  out  ADDR_WIDTH  current sequential pointer
- rd_overrun  out  1  sticky: request arrived while busy and was dropped
- mem_en  out  1  RAM read enable, one cycle per read
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_q  in  DATA_WIDTH  RAM read data

## Operation
- States:
  - IDLE: no read in progress.
  - ISSUE: drive mem_en = 1 for one cycle.
  - WAIT: count RAM latency.
  - DONE: rd_valid = 1 for one cycle.
- Transitions:
  - IDLE or DONE, rd_req = 1 → ISSUE.
  - IDLE or DONE, rd_req = 0 → IDLE.
  - ISSUE → WAIT; latency counter loads 1.
  - WAIT, cnt == MEM_LATENCY → DONE; capture mem_q into rd_data on that edge.
  - WAIT, otherwise → stay in WAIT; cnt increments.
- Address selection on the accept edge:
  - rd_inc = 0: mem_addr ← rd_addr; rd_ptr ← rd_addr + 1.
  - rd_inc = 1: mem_addr ← rd_ptr; rd_ptr ← rd_ptr + 1.
- Pointer arithmetic is modulo 2^ADDR_WIDTH; all-ones wraps to 0.
- mem_addr is held stable from ISSUE through DONE.
- rd_busy = 1 in ISSUE and WAIT; 0 in IDLE and DONE.
- Dropped request:
  - rd_req = 1 while rd_busy = 1 is dropped.
  - It sets rd_overrun and has no effect on state, pointer or mem_addr.
  - rd_overrun clears on the next accepted request or on reset.
  - If a dropped request and an accept coincide, the accept wins and the flag clears.
- rd_data changes only on the DONE-entry edge. rd_valid is never asserted without a capture.

## Timing
- Request accepted at edge E0. ISSUE runs during cycle E0–E1, and RAM samples mem_addr at E1.
- rd_data is captured at edge E(MEM_LATENCY+1). rd_valid is high for the cycle after that edge.
- Accept-to-valid is MEM_LATENCY+1 cycles:
  - MEM_LATENCY = 1: rd_valid in cycle after E2.
  - MEM_LATENCY = 2: rd_valid in cycle after E3.
- Back-to-back reads:
  - A request accepted in DONE goes directly to ISSUE.
  - Sustained throughput is one read per MEM_LATENCY+2 cycles.
- Reset values: rd_busy 0, rd_valid 0, rd_data 0, rd_ptr 0, rd_overrun 0, mem_en 0, mem_addr 0, state IDLE, cnt 0.
- Reset asserted mid-read:
  - Takes effect immediately and asynchronously; the pending read is abandoned.
  - No rd_valid is produced after reset release.
- All outputs are registered; no combinational path from input to output.

## Structure
- Shared processor package holds:
  - State encoding localparams: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3.
  - Default DATA_WIDTH and ADDR_WIDTH.
  - MAX_MEM_LATENCY = 7. The counter is 3 bits wide.
- One sub-module, rd_lat_counter: loadable up-counter with terminal-count compare against MEM_LATENCY.
- FSM, pointer and output registers live in mem_read_ctrl.

## Test plan
- Explicit read:
  - Stimulus: MEM_LATENCY = 2, RAM[0x0010] = 0xA5, pulse rd_req with rd_inc = 0, rd_addr = 0x0010.
  - Response: mem_en one cycle with mem_addr = 0x0010; rd_valid in cycle after E3 with rd_data = 0xA5; rd_ptr = 0x0011.
- Sequential reads:
  - Stimulus: RAM[0x20..0x22] = 0x11, 0x22, 0x33; one explicit read at 0x20, then two requests with rd_inc = 1 issued in DONE.
  - Response: rd_data 0x11, 0x22, 0x33 on three rd_valid strobes spaced 4 cycles apart; rd_ptr = 0x23.
- Pointer wrap:
  - Stimulus: explicit read at 0xFFFF, then one rd_inc read.
  - Response: second mem_addr = 0x0000; rd_ptr = 0x0001.
- Overrun:
  - Stimulus: rd_req held high during WAIT.
  - Response: rd_overrun = 1; mem_addr and rd_ptr unchanged; next accepted request clears rd_overrun.
- Reset mid-read:
  - Stimulus: assert reset for 3 ns during WAIT.
  - Response: all outputs 0 immediately; no rd_valid after release; rd_data stays 0.
- Latency sweep:
  - Stimulus: repeat the explicit-read scenario with MEM_LATENCY = 1 and MEM_LATENCY = 7.
  - Response: rd_valid appears 2 and 8 cycles after the accept edge respectively.

Source files
------------

// File: rtl/mem_read_ctrl_pkg.sv
// Shared definitions for the read-side memory sequencer: state encoding,
// default widths and the latency counter sizing.
package mem_read_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_ADDR_WIDTH  = 16;
    localparam int unsigned MAX_MEM_LATENCY = 7;
    localparam int unsigned CNT_WIDTH       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/mem_read_ctrl_if.sv
// Request/response and RAM-side signals of the read sequencer.
// slave = the sequencer, master = control unit plus RAM.
interface mem_read_ctrl_if
    import mem_read_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  rd_req;
    logic                  rd_inc;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_busy;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_overrun;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  rd_req, rd_inc, rd_addr, mem_q,
        output rd_busy, rd_valid, rd_data, rd_ptr, rd_overrun, mem_en, mem_addr
    );

    modport master (
        output rd_req, rd_inc, rd_addr, mem_q,
        input  rd_busy, rd_valid, rd_data, rd_ptr, rd_overrun, mem_en, mem_addr
    );
endinterface

// File: rtl/mem_read_ctrl_lat_counter.sv
// Loadable up-counter timing the RAM latency; tc flags cnt == MEM_LATENCY.
module rd_lat_counter
    import mem_read_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic tc
);
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_WIDTH'(1);
        end else if (inc) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    assign tc = (cnt == CNT_WIDTH'(MEM_LATENCY));
endmodule

// File: rtl/mem_read_ctrl.sv
// Read sequencer: accepts a one-cycle request, issues one RAM read, waits out
// the RAM latency and presents the word with a one-cycle valid strobe.
module mem_read_ctrl
    import mem_read_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned MEM_LATENCY = 1
) (
    input logic            clock,
    input logic            reset,
    mem_read_ctrl_if.slave bus
);
    rd_state_t             state, state_nxt;
    logic                  accept;
    logic                  lat_load, lat_inc, lat_tc;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, mem_addr_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_overrun_q;
    logic                  mem_en_o, rd_busy_o, rd_valid_o;

    rd_lat_counter #(.MEM_LATENCY(MEM_LATENCY)) u_lat (
        .clock (clock),
        .reset (reset),
        .load  (lat_load),
        .inc   (lat_inc),
        .tc    (lat_tc)
    );

    assign accept   = bus.rd_req && (state == IDLE || state == DONE);
    assign addr_sel = bus.rd_inc ? rd_ptr_q : bus.rd_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_load  = 1'b0;
        lat_inc   = 1'b0;
        unique case (state)
            IDLE, DONE: state_nxt = bus.rd_req ? ISSUE : IDLE;
            ISSUE: begin
                state_nxt = WAIT;
                lat_load  = 1'b1;
            end
            WAIT: begin
                if (lat_tc) begin
                    state_nxt = DONE;
                end else begin
                    lat_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode the state register only, so no input reaches an output.
    always_comb begin
        mem_en_o   = (state == ISSUE);
        rd_busy_o  = (state == ISSUE) || (state == WAIT);
        rd_valid_o = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr_q   <= '0;
            rd_ptr_q     <= '0;
            rd_data_q    <= '0;
            rd_overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr_q   <= addr_sel;
                rd_ptr_q     <= addr_sel + ADDR_WIDTH'(1);
                rd_overrun_q <= 1'b0;
            end else if (bus.rd_req) begin
                rd_overrun_q <= 1'b1;
            end
            if (state == WAIT && lat_tc) begin
                rd_data_q <= bus.mem_q;
            end
        end
    end

    assign bus.mem_en     = mem_en_o;
    assign bus.rd_busy    = rd_busy_o;
    assign bus.rd_valid   = rd_valid_o;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_overrun = rd_overrun_q;
endmodule

// File: tb/tb_mem_read_ctrl.sv
// Bench for mem_read_ctrl: three instances (latency 1, 2, 7), each with a
// behavioural RAM, checked against a pointer/latency model kept here.
module tb_mem_read_ctrl;
    import mem_read_ctrl_pkg::*;

    localparam int NI = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        req [NI];
    logic        inc [NI];
    logic [15:0] addr[NI];
    logic        busy[NI], valid[NI], ovr[NI], mem_en[NI];
    logic [7:0]  data[NI];
    logic [15:0] ptr [NI], maddr[NI];
    logic [7:0]  ram [0:65535];

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : 7;
        logic [7:0] pipe [L];

        mem_read_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

        mem_read_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_LATENCY(L)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.rd_req  = req[g];
        assign bus.rd_inc  = inc[g];
        assign bus.rd_addr = addr[g];
        assign bus.mem_q   = pipe[L-1];
        assign busy[g]     = bus.rd_busy;
        assign valid[g]    = bus.rd_valid;
        assign data[g]     = bus.rd_data;
        assign ptr[g]      = bus.rd_ptr;
        assign ovr[g]      = bus.rd_overrun;
        assign mem_en[g]   = bus.mem_en;
        assign maddr[g]    = bus.mem_addr;

        // RAM returns poison unless enabled, so a mistimed capture is visible.
        always @(posedge clock) begin
            pipe[0] <= bus.mem_en ? ram[bus.mem_addr] : 8'hEE;
            for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
        end
    end

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_ptr[NI];

    typedef struct {
        logic        en_i, busy_i, ovr_i;
        logic [15:0] addr_i, ptr_i;
        int          lat;
        bit          hold_ok;
        logic [7:0]  rdata;
        logic [15:0] addr_d;
        logic        busy_d, ovr_d;
        int          vcyc;
    } obs_t;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 7;
    endfunction

    function automatic logic [15:0] model_accept(input int k, input logic iv, input logic [15:0] av);
        logic [15:0] a;
        a = iv ? exp_ptr[k] : av;
        exp_ptr[k] = a + 16'd1;
        return a;
    endfunction

    // Issue one request on instance k and record what the DUT does; requests
    // are re-raised on edges dlo..dhi after the accept to provoke drops.
    task automatic do_read(input int k, input logic iv, input logic [15:0] av,
                           input int dlo, input int dhi, output obs_t o);
        int n;
        bit seen;
        req[k] = 1'b1; inc[k] = iv; addr[k] = av;
        @(posedge clock); #1;
        req[k] = 1'b0; inc[k] = 1'($urandom); addr[k] = 16'($urandom);
        o.en_i = mem_en[k]; o.busy_i = busy[k]; o.ovr_i = ovr[k];
        o.addr_i = maddr[k]; o.ptr_i = ptr[k];
        o.hold_ok = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 24) begin
            req[k] = (dlo > 0 && n + 1 >= dlo && n + 1 <= dhi);
            @(posedge clock); #1;
            n++;
            req[k] = 1'b0;
            if (valid[k] === 1'b1) seen = 1'b1;
            else if (mem_en[k] !== 1'b0 || busy[k] !== 1'b1 ||
                     maddr[k] !== o.addr_i || ptr[k] !== o.ptr_i) o.hold_ok = 1'b0;
        end
        o.lat = seen ? n : -1;
        o.rdata = data[k]; o.addr_d = maddr[k]; o.busy_d = busy[k]; o.ovr_d = ovr[k];
        o.vcyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({busy[k], valid[k], ovr[k], mem_en[k], data[k], ptr[k], maddr[k]} !== '0) begin
                errors++;
                $display("FAIL reset_values k=%0d got busy=%b valid=%b ovr=%b en=%b data=%h ptr=%h maddr=%h exp all 0",
                         k, busy[k], valid[k], ovr[k], mem_en[k], data[k], ptr[k], maddr[k]);
            end
        end
        reset = 1'b0;
        idle(2);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset k=%0d got busy=%b valid=%b exp 0 0", k, busy[k], valid[k]);
            end
        end
    endtask

    task automatic test_explicit();
        obs_t o;
        logic [15:0] a;
        ram[16'h0010] = 8'hA5;
        a = model_accept(1, 1'b0, 16'h0010);
        do_read(1, 1'b0, 16'h0010, 0, 0, o);
        checks++;
        if (o.en_i !== 1'b1 || o.busy_i !== 1'b1 || o.addr_i !== a) begin
            errors++;
            $display("FAIL explicit_issue got en=%b busy=%b addr=%h exp 1 1 %h", o.en_i, o.busy_i, o.addr_i, a);
        end
        checks++;
        if (o.lat !== 3 || o.hold_ok !== 1'b1) begin
            errors++;
            $display("FAIL explicit_latency got lat=%0d hold=%0d exp 3 1", o.lat, o.hold_ok);
        end
        checks++;
        if (o.rdata !== 8'hA5 || ptr[1] !== 16'h0011 || o.addr_d !== 16'h0010) begin
            errors++;
            $display("FAIL explicit_data got data=%h ptr=%h maddr=%h exp a5 0011 0010", o.rdata, ptr[1], o.addr_d);
        end
        idle(1);
        checks++;
        if (valid[1] !== 1'b0 || data[1] !== 8'hA5) begin
            errors++;
            $display("FAIL explicit_strobe_len got valid=%b data=%h exp 0 a5", valid[1], data[1]);
        end
    endtask

    task automatic test_sequential();
        obs_t o0, o1, o2;
        ram[16'h0020] = 8'h11; ram[16'h0021] = 8'h22; ram[16'h0022] = 8'h33;
        void'(model_accept(1, 1'b0, 16'h0020));
        do_read(1, 1'b0, 16'h0020, 0, 0, o0);
        void'(model_accept(1, 1'b1, 16'h0000));
        do_read(1, 1'b1, 16'h0000, 0, 0, o1);
        void'(model_accept(1, 1'b1, 16'h0000));
        do_read(1, 1'b1, 16'h0000, 0, 0, o2);
        checks++;
        if (o0.rdata !== 8'h11 || o1.rdata !== 8'h22 || o2.rdata !== 8'h33) begin
            errors++;
            $display("FAIL seq_data got %h %h %h exp 11 22 33", o0.rdata, o1.rdata, o2.rdata);
        end
        checks++;
        if (o1.vcyc - o0.vcyc !== 4 || o2.vcyc - o1.vcyc !== 4) begin
            errors++;
            $display("FAIL seq_spacing got %0d %0d exp 4 4", o1.vcyc - o0.vcyc, o2.vcyc - o1.vcyc);
        end
        checks++;
        if (ptr[1] !== 16'h0023 || exp_ptr[1] !== ptr[1]) begin
            errors++;
            $display("FAIL seq_ptr got %h exp 0023", ptr[1]);
        end
        idle(2);
    endtask

    task automatic test_wrap();
        obs_t o;
        void'(model_accept(1, 1'b0, 16'hFFFF));
        do_read(1, 1'b0, 16'hFFFF, 0, 0, o);
        checks++;
        if (o.ptr_i !== 16'h0000 || o.rdata !== ram[16'hFFFF]) begin
            errors++;
            $display("FAIL wrap_first got ptr=%h data=%h exp 0000 %h", o.ptr_i, o.rdata, ram[16'hFFFF]);
        end
        void'(model_accept(1, 1'b1, 16'h1234));
        do_read(1, 1'b1, 16'h1234, 0, 0, o);
        checks++;
        if (o.addr_i !== 16'h0000 || ptr[1] !== 16'h0001 || o.rdata !== ram[16'h0000]) begin
            errors++;
            $display("FAIL wrap_second got maddr=%h ptr=%h data=%h exp 0000 0001 %h",
                     o.addr_i, ptr[1], o.rdata, ram[16'h0000]);
        end
        idle(1);
    endtask

    task automatic test_overrun();
        obs_t o;
        logic [15:0] a;
        a = model_accept(2, 1'b0, 16'h0400);
        do_read(2, 1'b0, 16'h0400, 2, 6, o);
        checks++;
        if (o.ovr_d !== 1'b1 || o.hold_ok !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got ovr=%b hold=%0d exp 1 1", o.ovr_d, o.hold_ok);
        end
        checks++;
        if (o.addr_d !== a || ptr[2] !== exp_ptr[2] || o.rdata !== ram[a] || o.lat !== 8) begin
            errors++;
            $display("FAIL overrun_nochange got maddr=%h ptr=%h data=%h lat=%0d exp %h %h %h 8",
                     o.addr_d, ptr[2], o.rdata, o.lat, a, exp_ptr[2], ram[a]);
        end
        idle(2);
        checks++;
        if (ovr[2] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b exp 1", ovr[2]);
        end
        a = model_accept(2, 1'b1, 16'h0000);
        do_read(2, 1'b1, 16'h0000, 0, 0, o);
        checks++;
        if (o.ovr_i !== 1'b0 || o.addr_i !== a) begin
            errors++;
            $display("FAIL overrun_clear got ovr=%b maddr=%h exp 0 %h", o.ovr_i, o.addr_i, a);
        end
        idle(1);
    endtask

    task automatic test_latency_sweep();
        obs_t o;
        for (int k = 0; k < NI; k += 2) begin
            ram[16'h0010] = 8'($urandom);
            void'(model_accept(k, 1'b0, 16'h0010));
            do_read(k, 1'b0, 16'h0010, 0, 0, o);
            checks++;
            if (o.lat !== lat_of(k) + 1 || o.rdata !== ram[16'h0010] || o.hold_ok !== 1'b1) begin
                errors++;
                $display("FAIL latency_sweep k=%0d got lat=%0d data=%h hold=%0d exp %0d %h 1",
                         k, o.lat, o.rdata, o.hold_ok, lat_of(k) + 1, ram[16'h0010]);
            end
            idle(1);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [15:0] a, av;
        logic iv;
        int k, dlo, dhi;
        for (int t = 0; t < 60; t++) begin
            k  = int'($urandom_range(0, NI - 1));
            iv = 1'($urandom);
            av = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
            dlo = 0; dhi = 0;
            if ($urandom_range(0, 2) == 0) begin
                dlo = int'($urandom_range(1, lat_of(k)));
                dhi = int'($urandom_range(dlo, lat_of(k)));
            end
            a = model_accept(k, iv, av);
            do_read(k, iv, av, dlo, dhi, o);
            checks++;
            if (o.en_i !== 1'b1 || o.addr_i !== a || o.ptr_i !== exp_ptr[k] || o.ovr_i !== 1'b0) begin
                errors++;
                $display("FAIL rand_accept t=%0d k=%0d got en=%b maddr=%h ptr=%h ovr=%b exp 1 %h %h 0",
                         t, k, o.en_i, o.addr_i, o.ptr_i, o.ovr_i, a, exp_ptr[k]);
            end
            checks++;
            if (o.lat !== lat_of(k) + 1 || o.hold_ok !== 1'b1 || o.rdata !== ram[a] ||
                o.addr_d !== a || o.busy_d !== 1'b0 || o.ovr_d !== (dlo > 0)) begin
                errors++;
                $display("FAIL rand_complete t=%0d k=%0d got lat=%0d hold=%0d data=%h maddr=%h busy=%b ovr=%b exp %0d 1 %h %h 0 %b",
                         t, k, o.lat, o.hold_ok, o.rdata, o.addr_d, o.busy_d, o.ovr_d,
                         lat_of(k) + 1, ram[a], a, (dlo > 0));
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        req[2] = 1'b1; inc[2] = 1'b0; addr[2] = 16'h0055;
        @(posedge clock); #1;
        req[2] = 1'b0;
        idle(2);
        #3 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if ({busy[k], valid[k], ovr[k], mem_en[k], data[k], ptr[k], maddr[k]} !== '0) begin
                errors++;
                $display("FAIL midread_reset k=%0d got busy=%b valid=%b ovr=%b en=%b data=%h ptr=%h maddr=%h exp all 0",
                         k, busy[k], valid[k], ovr[k], mem_en[k], data[k], ptr[k], maddr[k]);
            end
            exp_ptr[k] = 16'h0000;
        end
        #2 reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clock); #1;
            checks++;
            if (valid[2] !== 1'b0 || data[2] !== 8'h00 || busy[2] !== 1'b0) begin
                errors++;
                $display("FAIL midread_after cyc=%0d got valid=%b data=%h busy=%b exp 0 00 0",
                         n, valid[2], data[2], busy[2]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; inc[k] = 1'b0; addr[k] = 16'h0000; exp_ptr[k] = 16'h0000;
        end
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        test_reset();
        test_explicit();
        test_sequential();
        test_wrap();
        test_overrun();
        test_latency_sweep();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
